booth_seq_mul: RTL and testbench

Iterative radix-4 Booth multiplier for unsigned operands. It scans `operand_b_i` two bits per cycle, generates one Booth partial product per cycle and accumulates it. It is the area-lean, multi-cycle alternative to the fully parallel partial-product array, for mantissa products where throughput is not critical. Operands arrive and results leave on valid/ready handshakes; a `clear_i` abort is provided for pipeline flushes.

---
 rtl/booth_seq_mul.sv | 103 ++++++++++
 tb/tb_booth_seq_mul.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/booth_seq_mul.sv
// Iterative radix-4 Booth multiplier for unsigned operands.
// Scans two multiplier bits per cycle and accumulates one partial product per step.
module booth_seq_mul #(
    parameter  int WIDTH_A = 16,
    parameter  int WIDTH_B = 16,
    localparam int COUNT   = (WIDTH_B + 2) / 2,
    localparam int WIDTH_O = WIDTH_A + WIDTH_B
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH_A-1:0] operand_a_i,
    input  logic [WIDTH_B-1:0] operand_b_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [WIDTH_O-1:0] result_o,
    output logic               busy_o
);

    localparam int KW = $clog2(COUNT);
    localparam int PW = WIDTH_O + 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t               state;
    logic [WIDTH_A-1:0]   a_q;
    logic [WIDTH_B+2:0]   m_q;
    logic [WIDTH_O-1:0]   acc_q;
    logic [KW-1:0]        k_q;

    logic [KW:0]          shamt;
    logic [2:0]           code;
    logic [PW-1:0]        a_ext;
    logic [PW-1:0]        pp;
    logic [WIDTH_O-1:0]   addend;

    // Partial product is formed at WIDTH_O+2 bits so negative terms wrap correctly before truncation.
    always_comb begin
        shamt  = {k_q, 1'b0};
        code   = 3'(m_q >> shamt);
        a_ext  = PW'(a_q);
        pp     = '0;
        case (code)
            3'b001, 3'b010: pp = a_ext;
            3'b011:         pp = a_ext << 1;
            3'b100:         pp = -(a_ext << 1);
            3'b101, 3'b110: pp = -a_ext;
            default:        pp = '0;
        endcase
        addend = WIDTH_O'(pp << shamt);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            a_q   <= '0;
            m_q   <= '0;
            acc_q <= '0;
            k_q   <= '0;
        end else if (clear_i) begin
            state <= IDLE;
            acc_q <= '0;
            k_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        a_q   <= operand_a_i;
                        m_q   <= {2'b00, operand_b_i, 1'b0};
                        acc_q <= '0;
                        k_q   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_q + addend;
                    k_q   <= k_q + KW'(1);
                    if (k_q == KW'(COUNT - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = (state == IDLE);
    assign out_valid_o = (state == DONE);
    assign busy_o      = (state == RUN) || (state == DONE);
    assign result_o    = acc_q;

endmodule

// File: tb/tb_booth_seq_mul.sv
// Self-checking bench for booth_seq_mul: directed cases plus a random run
// compared against the plain arithmetic product a*b.
module tb_booth_seq_mul;

    localparam int WA = 16;
    localparam int WB = 16;
    localparam int WO = WA + WB;
    localparam int LAT = (WB + 2) / 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [WA-1:0] operand_a;
    logic [WB-1:0] operand_b;
    logic          out_valid;
    logic          out_ready;
    logic [WO-1:0] result;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    booth_seq_mul #(.WIDTH_A(WA), .WIDTH_B(WB)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (clear),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .operand_a_i (operand_a),
        .operand_b_i (operand_b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .busy_o      (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WO-1:0] ref_mul(input logic [WA-1:0] a, input logic [WB-1:0] b);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        return WO'(p);
    endfunction

    // Issue one operation; hold = cycles spent in DONE with out_ready low.
    task automatic run_op(input logic [WA-1:0] a, input logic [WB-1:0] b, input int hold,
                          input bit verbose);
        int n;
        logic [WO-1:0] exp;
        exp = ref_mul(a, b);
        if (verbose) check("ready_before_accept", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        operand_a = a;
        operand_b = b;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        operand_a = ~a;
        operand_b = ~b;
        n = 0;
        while (!out_valid && n < 30) begin
            if (verbose && n > 0) check("busy_in_run", 64'(busy), 64'd1);
            @(posedge clk); #1;
            n++;
        end
        check("latency", 64'(n), 64'(LAT));
        check("result", 64'(result), 64'(exp));
        if (verbose) check("no_ready_in_done", 64'(in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_result", 64'(result), 64'(exp));
            check("hold_no_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("valid_one_cycle", 64'(out_valid), 64'd0);
        check("ready_after_done", 64'(in_ready), 64'd1);
    endtask

    initial begin
        int seen;
        logic [WA-1:0] ra;
        logic [WB-1:0] rb;

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        operand_a = '0; operand_b = '0;
        #12;
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(16'h1234, 16'h5678, 0, 1'b1);
        check("dir_1234x5678", 64'(result), 64'h06260060);
        run_op(16'hFFFF, 16'hFFFF, 0, 1'b1);
        run_op(16'h0003, 16'h0002, 0, 1'b1);
        run_op(16'hABCD, 16'h0000, 0, 1'b1);
        run_op(16'h0000, 16'hFFFF, 0, 1'b1);
        run_op(16'h00FF, 16'h0101, 5, 1'b1);

        // clear during RUN
        in_valid = 1'b1; operand_a = 16'hBEEF; operand_b = 16'hCAFE;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1; clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clear_idle", 64'(in_ready), 64'd1);
        check("clear_busy", 64'(busy), 64'd0);
        check("clear_result", 64'(result), 64'd0);
        seen = 0;
        out_ready = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        out_ready = 1'b0;
        check("clear_no_valid", 64'(seen), 64'd0);

        // clear with in_valid in IDLE must not accept
        clear = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        check("clear_blocks_accept", 64'(busy), 64'd0);

        run_op(16'h0002, 16'h0005, 0, 1'b1);
        check("after_clear_2x5", 64'(result), 64'd10);

        // asynchronous reset between edges mid-RUN
        in_valid = 1'b1; operand_a = 16'h1111; operand_b = 16'h2222;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2; rst = 1'b1;
        #1;
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_ready", 64'(in_ready), 64'd1);
        check("async_rst_result", 64'(result), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 1000; v++) begin
            ra = WA'($urandom);
            rb = WB'($urandom);
            if (v % 7 == 0) ra = '1;
            if (v % 11 == 0) rb = '1;
            run_op(ra, rb, (v % 13 == 0) ? 2 : 0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
